cond_resolve: RTL
=================

# cond_resolve

Execute-to-memory condition resolver for the pipelined Y86-64 core. It is the consumer (read side) of the condition-code register. It evaluates ZF/SF/OF against the `ifun` of `jXX` and `cmovXX` instructions in E and registers the outcome into the M stage. Under the always-taken branch prediction policy, it detects mispredicted jumps and drives a fixed-length squash/redirect sequence to fetch and decode.

## Interface
Parameters:
- `W`, 64, address/data width of `e_valA` and `redirect_pc`
- `SQUASH_CYCLES`, 2, cycles `squash` is held after a mispredict (legal range 1..7)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `async_reset`  in  1  asynchronous, active-low reset
- `cc_in`  in  3  current CC register output: [2]=ZF, [1]=SF, [0]=OF
- `e_valid`  in  1  E stage holds a real instruction (0 = bubble)
- `e_icode`  in  4  E-stage icode
- `e_ifun`  in  4  E-stage ifun
- `e_valA`  in  W  fall-through PC (valP) for `jXX`
- `e_dstE`  in  4  E-stage destination register
- `stall_in`  in  1  freeze M register and FSM this cycle
- `m_valid`  out  1  M stage holds a real instruction
- `m_cnd`  out  1  resolved condition
- `m_dstE`  out  4  `e_dstE`, forced to RNONE (4'hF) for a not-taken `cmovXX`
- `m_illegal`  out  1  `jXX`/`cmovXX` with ifun > 6
- `mispredict`  out  1  one-cycle pulse: `jXX` resolved not-taken
- `redirect_pc`  out  W  valP of the mispredicted jump; valid while `mispredict`=1
- `squash`  out  1  kill D and E contents (insert bubbles)

## Operation
- Conditions, with lt = SF^OF:
  - ifun 0: always 1
  - ifun 1 (le): lt|ZF
  - ifun 2 (l): lt
  - ifun 3 (e): ZF
  - ifun 4 (ne): ~ZF
  - ifun 5 (ge): ~lt
  - ifun 6 (g): ~lt & ~ZF
  - ifun 7..15: cnd=0, illegal=1
- Evaluation applies only for icode 2 (rrmovq/cmovXX) and icode 7 (jXX). For all other icodes, cnd=1 and illegal=0. `m_dstE` passes through unchanged.
- `cc_in` is the already-updated register value. Same-cycle `set_cc` by the preceding instruction is visible through the CC register's edge; no internal forwarding.
- FSM states:
  - RUN: capture E each unstalled cycle. If a captured valid `jXX` has cnd=0, go to RECOVER and assert `mispredict` with `redirect_pc`=captured `e_valA`.
  - RECOVER: `squash`=1; a down-counter loaded with SQUASH_CYCLES decrements each unstalled cycle and returns to RUN at 0. Incoming E instructions are captured as bubbles (`m_valid`=0).
- A `jXX` with ifun>6 is treated as not-taken: mispredict and `m_illegal`=1.
- `stall_in`=1 holds all M outputs, the FSM state and the counter. A `mispredict` pulse pending under stall is held until the first unstalled cycle, then drops.
- Reset: asynchronous to RUN; all outputs 0 except `m_dstE`=4'hF and `redirect_pc`=0. Reset during RECOVER aborts the squash immediately.

## Timing
- Latency E→M is 1 cycle: cnd is combinational on `cc_in` and `e_*` in cycle k, and appears on `m_*` in cycle k+1.
- `mispredict` and `redirect_pc` appear in cycle k+1, in the same cycle as `m_cnd`=0.
- `squash` is high in cycles k+1 .. k+SQUASH_CYCLES when there is no stall; each stall cycle extends the window by 1.
- There is no combinational path from inputs to outputs. All outputs are registered.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: IRRMOVQ=2, IJXX=7
  - condition ifun constants: C_ALWAYS..C_G
  - CC bit indices: ZF_BIT, SF_BIT, OF_BIT
  - RNONE=4'hF
- Sub-module `cond_eval`: purely combinational (`cc`, `ifun`) → (`cnd`, `illegal`). It is reused by the sequential (SEQ) core.
- Top level: M register, 2-state FSM, squash counter of width clog2(SQUASH_CYCLES+1).

## Test plan
- Sweep `jXX` ifun 0..6 across all 8 `cc_in` values (check taken cases): `m_cnd` matches the condition list; `mispredict` pulses only when cnd=0.
- `cmovle`, `cc_in`=3'b000, `e_dstE`=3 → cycle k+1: `m_cnd`=0, `m_dstE`=4'hF, `m_valid`=1.
- `jne` with `cc_in`=3'b100, `e_valA`=64'h1234, SQUASH_CYCLES=2 → `mispredict`=1 and `redirect_pc`=64'h1234 at k+1; `squash` high at k+1 and k+2; valid E at k+1 gives `m_valid`=0.
- Mispredict followed by `stall_in` at k+2 → `squash` stays high through k+3; all outputs frozen during the stall.
- `cmov` with ifun=9 → `m_illegal`=1 and `m_cnd`=0. Same for `jXX` ifun=9, which also produces `mispredict`.
- Assert `async_reset`=0 mid-RECOVER (between edges) → `squash`=0, `m_valid`=0 and `m_dstE`=4'hF immediately; RUN after release.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and payload types for the condition logic.
package y86_pkg;

   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IJXX    = 4'h7;

   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   localparam int unsigned ZF_BIT = 2;
   localparam int unsigned SF_BIT = 1;
   localparam int unsigned OF_BIT = 0;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic {
      S_RUN     = 1'b0,
      S_RECOVER = 1'b1
   } resolve_state_t;

   // M-stage payload
   typedef struct packed {
      logic       valid;
      logic       cnd;
      logic [3:0] dst_e;
      logic       illegal;
   } m_reg_t;

   // Bubble content, also the reset value of the M register
   localparam m_reg_t M_BUBBLE = '{valid: 1'b0, cnd: 1'b0, dst_e: RNONE, illegal: 1'b0};

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a jXX/cmovXX condition against ZF/SF/OF.
module cond_eval
   import y86_pkg::*;
(
   input  logic [2:0] cc,
   input  logic [3:0] ifun,
   output logic       cnd,
   output logic       illegal
);

   logic zf;
   logic lt;

   assign zf = cc[ZF_BIT];
   assign lt = cc[SF_BIT] ^ cc[OF_BIT];

   // Condition decode; undefined ifun codes never fire and flag illegal
   always_comb begin
      cnd     = 1'b0;
      illegal = 1'b0;
      case (ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = lt | zf;
         C_L:      cnd = lt;
         C_E:      cnd = zf;
         C_NE:     cnd = ~zf;
         C_GE:     cnd = ~lt;
         C_G:      cnd = ~lt & ~zf;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_resolve.sv
// E->M condition resolver: registers the outcome into M and sequences squash on a mispredicted jump.
module cond_resolve
   import y86_pkg::*;
#(
   parameter int unsigned W             = 64,
   parameter int unsigned SQUASH_CYCLES = 2
) (
   input  logic         clk,
   input  logic         async_reset,
   input  logic [2:0]   cc_in,
   input  logic         e_valid,
   input  logic [3:0]   e_icode,
   input  logic [3:0]   e_ifun,
   input  logic [W-1:0] e_valA,
   input  logic [3:0]   e_dstE,
   input  logic         stall_in,
   output logic         m_valid,
   output logic         m_cnd,
   output logic [3:0]   m_dstE,
   output logic         m_illegal,
   output logic         mispredict,
   output logic [W-1:0] redirect_pc,
   output logic         squash
);

   localparam int unsigned CNT_W = $clog2(SQUASH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SQUASH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   resolve_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   m_reg_t           m_q, m_d;
   logic             mispredict_d;
   logic [W-1:0]     redirect_d;
   logic             squash_d;

   logic raw_cnd, raw_illegal;
   logic eval_en, e_cnd, e_illegal;

   cond_eval u_cond_eval (
      .cc      (cc_in),
      .ifun    (e_ifun),
      .cnd     (raw_cnd),
      .illegal (raw_illegal)
   );

   // Only rrmovq/cmovXX and jXX are conditional; everything else resolves true
   assign eval_en   = (e_icode == IRRMOVQ) || (e_icode == IJXX);
   assign e_cnd     = eval_en ? raw_cnd : 1'b1;
   assign e_illegal = eval_en & raw_illegal;

   // Next-state and next-output logic; a stall holds everything
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      m_d          = m_q;
      mispredict_d = mispredict;
      redirect_d   = redirect_pc;
      squash_d     = squash;
      if (!stall_in) begin
         mispredict_d = 1'b0;
         case (state)
            S_RUN: begin
               m_d.valid   = e_valid;
               m_d.cnd     = e_cnd;
               m_d.illegal = e_illegal;
               m_d.dst_e   = ((e_icode == IRRMOVQ) && !e_cnd) ? RNONE : e_dstE;
               squash_d    = 1'b0;
               if (e_valid && (e_icode == IJXX) && !e_cnd) begin
                  state_nxt    = S_RECOVER;
                  cnt_nxt      = CNT_LOAD;
                  mispredict_d = 1'b1;
                  redirect_d   = e_valA;
                  squash_d     = 1'b1;
               end
            end
            S_RECOVER: begin
               m_d      = M_BUBBLE;
               cnt_nxt  = cnt - CNT_ONE;
               squash_d = 1'b1;
               if (cnt == CNT_ONE) begin
                  state_nxt = S_RUN;
                  squash_d  = 1'b0;
               end
            end
            default: state_nxt = S_RUN;
         endcase
      end
   end

   // State, counter and all registered outputs
   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         state       <= S_RUN;
         cnt         <= '0;
         m_q         <= M_BUBBLE;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
         squash      <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         m_q         <= m_d;
         mispredict  <= mispredict_d;
         redirect_pc <= redirect_d;
         squash      <= squash_d;
      end
   end

   assign m_valid   = m_q.valid;
   assign m_cnd     = m_q.cnd;
   assign m_dstE    = m_q.dst_e;
   assign m_illegal = m_q.illegal;

endmodule
